// File: rtl/latch_gate_ctrl.sv
// latch_gate_ctrl: sequences a write into a downstream level-sensitive latch.
// D is set up with the gate G low, then G is opened for a fixed number of
// cycles, and D is held after G closes before ACK signals completion.
// Optional readback checking of the latch output Q is compiled in only when
// the macro LATCH_GATE_READBACK_EN is defined; otherwise ERR is tied low.
module latch_gate_ctrl #(
    parameter int W         = 1,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ,
    input  logic [W-1:0] DIN,
    output logic         BUSY,
    output logic         ACK,
    output logic         G,
    output logic [W-1:0] D,
    input  logic [W-1:0] Q,
    output logic         ERR
);

    // A zero-length phase still occupies one cycle.
    localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int OPEN_N  = (OPEN_CYC  < 1) ? 1 : OPEN_CYC;
    localparam int HOLD_N  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int MAX_SO  = (SETUP_N > OPEN_N) ? SETUP_N : OPEN_N;
    localparam int MAX_N   = (MAX_SO > HOLD_N) ? MAX_SO : HOLD_N;
    // The counter holds (phase length - 1) down to 0.
    localparam int CW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_N - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_N - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    d_q,     d_d;
    logic            g_q,     g_d;
    logic            busy_q,  busy_d;
    logic            ack_q,   ack_d;

    // Next-state, shared down-counter and data capture; outputs are decoded
    // from the next state so they can be registered without extra latency.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        unique case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    d_d     = DIN;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_OPEN;
                    cnt_d   = OPEN_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        g_d    = (state_d == S_OPEN);
        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_DONE);
    end

    // State, counter and registered outputs; reset closes the gate at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            g_q     <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign G    = g_q;
    assign D    = d_q;
    assign BUSY = busy_q;
    assign ACK  = ack_q;

`ifdef LATCH_GATE_READBACK_EN
    logic err_q, err_d;

    // Compare the latch output against D on the last open cycle; sticky.
    always_comb begin
        err_d = err_q;
        if ((state_q == S_OPEN) && (cnt_q == '0) && (Q != d_q)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    // Readback disabled: Q is deliberately unused and ERR never asserts.
    logic unused_q;
    assign unused_q = ^Q;
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_latch_gate_ctrl.sv
// Directed testbench for latch_gate_ctrl with W=1 and default timing.
// "Cycle n" is the interval after rising edge n, where edge 0 accepts REQ.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_latch_gate_ctrl;

    logic clk;
    logic rst_n;
    logic req;
    logic din;
    logic busy;
    logic ack;
    logic g;
    logic d;
    logic q;
    logic err;

    // Behavioural model of the downstream latch, with an override to force Q.
    logic lat = 1'b0;
    logic q_force_en = 1'b0;
    logic q_force = 1'b0;

    int total = 0;
    int bad = 0;

`ifdef LATCH_GATE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    latch_gate_ctrl #(
        .W(1),
        .SETUP_CYC(1),
        .OPEN_CYC(2),
        .HOLD_CYC(1)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .REQ(req),
        .DIN(din),
        .BUSY(busy),
        .ACK(ack),
        .G(g),
        .D(d),
        .Q(q),
        .ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_latch begin
        if (g) lat = d;
    end

    assign q = q_force_en ? q_force : lat;

    // Reset values, and REQ sampled at the first edge after reset release.
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b1;
        din   = 1'b1;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (ack  !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", ack); end
        total++; if (g    !== 1'b0) begin bad++; $display("FAIL reset_g got %b want 0", g); end
        total++; if (d    !== 1'b0) begin bad++; $display("FAIL reset_d got %b want 0", d); end
        total++; if (err  !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_reset_accept_busy got %b want 1", busy); end
        total++; if (d    !== 1'b1) begin bad++; $display("FAIL post_reset_accept_d got %b want 1", d); end
        req = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle_busy got %b want 0", busy); end
    endtask

    // One write of 1: checks the full cycle-by-cycle waveform.
    task automatic test_single();
        logic [1:6] eb, eg, ea, ed;
        eb = 6'b111110;
        eg = 6'b011000;
        ea = 6'b000010;
        ed = 6'b111111;
        req = 1'b1;
        din = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (busy !== eb[c]) begin bad++; $display("FAIL single_busy cycle %0d got %b want %b", c, busy, eb[c]); end
            total++; if (g    !== eg[c]) begin bad++; $display("FAIL single_g cycle %0d got %b want %b", c, g, eg[c]); end
            total++; if (ack  !== ea[c]) begin bad++; $display("FAIL single_ack cycle %0d got %b want %b", c, ack, ea[c]); end
            total++; if (d    !== ed[c]) begin bad++; $display("FAIL single_d cycle %0d got %b want %b", c, d, ed[c]); end
            total++; if (err  !== 1'b0)  begin bad++; $display("FAIL single_err cycle %0d got %b want 0", c, err); end
            req = 1'b0;
        end
    endtask

    // REQ pulses and DIN changes while busy must be ignored.
    task automatic test_ignore();
        logic [1:12] eb, ea;
        int acks;
        eb = 12'b111110_000000;
        ea = 12'b000010_000000;
        acks = 0;
        req = 1'b1;
        din = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
            total++; if (busy !== eb[c]) begin bad++; $display("FAIL ignore_busy cycle %0d got %b want %b", c, busy, eb[c]); end
            total++; if (ack  !== ea[c]) begin bad++; $display("FAIL ignore_ack cycle %0d got %b want %b", c, ack, ea[c]); end
            total++; if (d    !== 1'b1)  begin bad++; $display("FAIL ignore_d cycle %0d got %b want 1", c, d); end
            din = 1'b0;
            req = (c == 2 || c == 5) ? 1'b1 : 1'b0;
        end
        total++; if (acks != 1) begin bad++; $display("FAIL ignore_ack_count got %0d want 1", acks); end
    endtask

    // REQ held high: second transaction starts on the edge after IDLE returns.
    task automatic test_back_to_back();
        logic [1:12] eb, eg, ea, ed;
        eb = 12'b111110_111110;
        eg = 12'b011000_011000;
        ea = 12'b000010_000010;
        ed = 12'b000000_111111;
        req = 1'b1;
        din = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++; if (busy !== eb[c]) begin bad++; $display("FAIL b2b_busy cycle %0d got %b want %b", c, busy, eb[c]); end
            total++; if (g    !== eg[c]) begin bad++; $display("FAIL b2b_g cycle %0d got %b want %b", c, g, eg[c]); end
            total++; if (ack  !== ea[c]) begin bad++; $display("FAIL b2b_ack cycle %0d got %b want %b", c, ack, ea[c]); end
            total++; if (d    !== ed[c]) begin bad++; $display("FAIL b2b_d cycle %0d got %b want %b", c, d, ed[c]); end
            total++; if (err  !== 1'b0)  begin bad++; $display("FAIL b2b_err cycle %0d got %b want 0", c, err); end
            req = (c <= 6) ? 1'b1 : 1'b0;
            din = (c >= 2) ? 1'b1 : 1'b0;
        end
    endtask

    // Asynchronous reset while G is open: gate closes at once, no ACK.
    task automatic test_mid_reset();
        req = 1'b1;
        din = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_c1_busy got %b want 1", busy); end
        req = 1'b0;
        @(negedge clk);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL midrst_c2_g got %b want 1", g); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (g    !== 1'b0) begin bad++; $display("FAIL midrst_g got %b want 0", g); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        total++; if (d    !== 1'b0) begin bad++; $display("FAIL midrst_d got %b want 0", d); end
        total++; if (ack  !== 1'b0) begin bad++; $display("FAIL midrst_ack got %b want 0", ack); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (ack  !== 1'b0) begin bad++; $display("FAIL midrst_after_ack step %0d got %b want 0", c, ack); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_after_busy step %0d got %b want 0", c, busy); end
            total++; if (g    !== 1'b0) begin bad++; $display("FAIL midrst_after_g step %0d got %b want 0", c, g); end
        end
    endtask

    // Q forced low while writing 1: ERR sets from cycle 4 (only with readback).
    task automatic test_readback();
        logic exp_err;
        q_force_en = 1'b1;
        q_force    = 1'b0;
        req = 1'b1;
        din = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_err = RB && (c >= 4);
            total++; if (err !== exp_err) begin bad++; $display("FAIL rb_mismatch_err cycle %0d got %b want %b", c, err, exp_err); end
            req = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rb_err_reset got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        q_force_en = 1'b0;
        req = 1'b1;
        din = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (err !== 1'b0) begin bad++; $display("FAIL rb_match_err cycle %0d got %b want 0", c, err); end
            total++; if (ack !== (c == 5)) begin bad++; $display("FAIL rb_match_ack cycle %0d got %b want %b", c, ack, (c == 5)); end
            req = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        din   = 1'b0;
        test_reset();
        test_single();
        test_ignore();
        test_back_to_back();
        test_mid_reset();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
